seq_approx_divider: RTL and testbench

Sequential, parameterised restoring divider. It divides a 2·DW-bit dividend by a DW-bit divisor and returns a DW-bit quotient and a DW-bit remainder. The last APPROX_ROWS iterations can use the approximate subtractor cell, selectable per operation at run time. Throughput/area trade-off is set by ROWS_PER_CYCLE. It replaces fixed combinational array dividers in the accuracy/delay exploration flow and adds valid/ready handshakes on both sides.

---
 rtl/seq_approx_divider.sv | 132 +++++++++++++
 tb/tb_seq_approx_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_approx_divider.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor with valid/ready on both
// sides. The least significant APPROX_ROWS quotient rows can use an approximate subtractor cell.
module seq_approx_divider #(
   parameter int DW             = 8,
   parameter int APPROX_ROWS    = 6,
   parameter int ROWS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] n,
   input  logic [DW-1:0]   d,
   input  logic            approx_en,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   q,
   output logic [DW-1:0]   r,
   output logic            ovf,
   output logic            dz
);

   localparam int KW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_next;
   logic [DW-1:0] n_lo, d_q, w, q_acc;
   logic          approx_q;
   logic [KW-1:0] k_cnt;

   logic [DW-1:0] w_row, w_step, q_step;
   logic [KW-1:0] row_k;
   logic [DW:0]   t, diff;
   logic          qb, last_step, accept;

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // Unrolled rows for one clock, evaluated in descending k from the current counter value.
   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      w_row  = w;
      q_step = q_acc;
      row_k  = '0;
      t      = '0;
      diff   = '0;
      qb     = 1'b0;
      for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
         row_k = k_cnt - KW'(j);
         t     = {w_row, n_lo[row_k]};
         diff  = t - {1'b0, d_q};
         if (approx_q && (int'(row_k) < APPROX_ROWS)) begin
            // Collapsed borrow chain: the partial remainder passes through unchanged.
            qb    = t[DW] | (t[DW-1] & ~d_q[DW-1]);
            w_row = t[DW-1:0];
         end else begin
            qb    = (t >= {1'b0, d_q});
            w_row = qb ? diff[DW-1:0] : t[DW-1:0];
         end
         q_step[row_k] = qb;
      end
      w_step    = w_row;
      last_step = (k_cnt == KW'(ROWS_PER_CYCLE - 1));
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)    state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: the datapath is a handful of flops, not a memory, so all of it is reset
   // to keep outputs and internal state deterministic after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_lo      <= '0;
         d_q       <= '0;
         approx_q  <= 1'b0;
         w         <= '0;
         q_acc     <= '0;
         k_cnt     <= '0;
         q         <= '0;
         r         <= '0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  n_lo     <= n[DW-1:0];
                  d_q      <= d;
                  approx_q <= approx_en;
                  w        <= n[2*DW-1:DW];
                  q_acc    <= '0;
                  k_cnt    <= KW'(DW - 1);
                  ovf      <= (n[2*DW-1:DW] >= d);
                  dz       <= (d == '0);
               end
            end
            RUN: begin
               w     <= w_step;
               q_acc <= q_step;
               k_cnt <= k_cnt - KW'(ROWS_PER_CYCLE);
               if (last_step) begin
                  q         <= q_step;
                  r         <= w_step;
                  out_valid <= 1'b1;
                  k_cnt     <= '0;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed-vector bench for seq_approx_divider (defaults DW=8, APPROX_ROWS=6, ROWS_PER_CYCLE=1),
// plus backpressure, mid-run reset and a short random run against a behavioural model.
module tb_seq_approx_divider;

   localparam int DW  = 8;
   localparam int AR  = 6;
   localparam int RPC = 1;
   localparam int LAT = DW / RPC;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2*DW-1:0] n;
   logic [DW-1:0]   d;
   logic            approx_en;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   q;
   logic [DW-1:0]   r;
   logic            ovf;
   logic            dz;

   int checks = 0;
   int errors = 0;

   seq_approx_divider #(.DW(DW), .APPROX_ROWS(AR), .ROWS_PER_CYCLE(RPC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .n(n), .d(d),
      .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready),
      .q(q), .r(r), .ovf(ovf), .dz(dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*DW-1:0] n;
      logic [DW-1:0]   d;
      logic            ap;
      logic [DW-1:0]   eq;
      logic [DW-1:0]   er;
      logic            eovf;
      logic            edz;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model(input logic [2*DW-1:0] nn, input logic [DW-1:0] dd, input logic ap,
                        output logic [DW-1:0] qq, output logic [DW-1:0] rr);
      logic [DW-1:0] w;
      logic [DW:0]   t;
      w  = nn[2*DW-1:DW];
      qq = '0;
      for (int k = DW - 1; k >= 0; k--) begin
         t = {w, nn[k]};
         if (ap && k < AR) begin
            qq[k] = t[DW] | (t[DW-1] & ~dd[DW-1]);
            w     = t[DW-1:0];
         end else begin
            qq[k] = (t >= {1'b0, dd});
            w     = qq[k] ? DW'(t - {1'b0, dd}) : t[DW-1:0];
         end
      end
      rr = w;
   endtask

   // One full transaction: accept, scramble operands, wait for out_valid, then hand-shake out.
   task automatic run_op(input logic [2*DW-1:0] nn, input logic [DW-1:0] dd, input logic ap,
                         output logic [DW-1:0] qq, output logic [DW-1:0] rr,
                         output logic ov, output logic dzz, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      n = nn; d = dd; approx_en = ap; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      n         = (2*DW)'($urandom);
      d         = DW'($urandom);
      approx_en = ~ap;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      qq = q; rr = r; ov = ovf; dzz = dz;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] aq, ar_, mq, mr;
      logic          aovf, adz;
      int            lat, guard;
      logic [2*DW-1:0] rn;
      logic [DW-1:0]   rd;
      logic            rap;

      vecs[0] = '{16'h03E8, 8'd7,   1'b0, 8'd142,  8'd6,   1'b0, 1'b0};
      vecs[1] = '{16'h00FF, 8'd1,   1'b1, 8'hC0,   8'd63,  1'b0, 1'b0};
      vecs[2] = '{16'h00FF, 8'd1,   1'b0, 8'hFF,   8'd0,   1'b0, 1'b0};
      vecs[3] = '{16'h1234, 8'd0,   1'b0, 8'hFF,   8'h34,  1'b1, 1'b1};
      vecs[4] = '{16'h0900, 8'd8,   1'b0, 8'hFF,   8'h08,  1'b1, 1'b0};
      vecs[5] = '{16'd100,  8'd9,   1'b0, 8'd11,   8'd1,   1'b0, 1'b0};
      vecs[6] = '{16'hFEFF, 8'hFF,  1'b0, 8'hFF,   8'hFE,  1'b0, 1'b0};
      vecs[7] = '{16'h0F00, 8'h10,  1'b1, 8'hC7,   8'h00,  1'b0, 1'b0};
      vecs[8] = '{16'h0064, 8'd9,   1'b1, 8'h00,   8'h64,  1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; n = '0; d = '0; approx_en = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset q", 32'(q), 32'd0);
      check("reset r", 32'(r), 32'd0);
      check("reset ovf_dz", 32'({ovf, dz}), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready after reset", 32'(in_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].n, vecs[i].d, vecs[i].ap, aq, ar_, aovf, adz, lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
         check($sformatf("vec%0d q", i), 32'(aq), 32'(vecs[i].eq));
         check($sformatf("vec%0d r", i), 32'(ar_), 32'(vecs[i].er));
         check($sformatf("vec%0d ovf", i), 32'(aovf), 32'(vecs[i].eovf));
         check($sformatf("vec%0d dz", i), 32'(adz), 32'(vecs[i].edz));
         check($sformatf("vec%0d out_valid drop", i), 32'(out_valid), 32'd0);
      end

      // Backpressure: result must hold, and in_valid pulses must be ignored.
      n = 16'h03E8; d = 8'd7; approx_en = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("bp out_valid reached", 32'(out_valid), 32'd1);
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0]; n = 16'h0101; d = 8'd3;
         @(posedge clk); #1;
         check("bp q hold", 32'(q), 32'd142);
         check("bp r hold", 32'(r), 32'd6);
         check("bp out_valid hold", 32'(out_valid), 32'd1);
         check("bp in_ready low", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready", 32'(in_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("bp no phantom op", 32'(out_valid), 32'd0);

      // Reset in the middle of a run abandons the operation.
      n = 16'h03E8; d = 8'd7; approx_en = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst q", 32'(q), 32'd0);
      check("midrst r", 32'(r), 32'd0);
      check("midrst in_ready during rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("midrst in_ready after", 32'(in_ready), 32'd1);
      run_op(16'd100, 8'd9, 1'b0, aq, ar_, aovf, adz, lat);
      check("post-rst q", 32'(aq), 32'd11);
      check("post-rst r", 32'(ar_), 32'd1);
      check("post-rst latency", 32'(lat), 32'(LAT));

      // Short random run against the behavioural model and true division.
      for (int i = 0; i < 40; i++) begin
         rn  = (2*DW)'($urandom);
         rd  = DW'($urandom);
         rap = 1'($urandom);
         if (i % 3 == 0) rn[2*DW-1:DW] = rn[2*DW-1:DW] % (rd | 8'h01);
         run_op(rn, rd, rap, aq, ar_, aovf, adz, lat);
         model(rn, rd, rap, mq, mr);
         check("rand q", 32'(aq), 32'(mq));
         check("rand r", 32'(ar_), 32'(mr));
         check("rand ovf", 32'(aovf), 32'(rn[2*DW-1:DW] >= rd));
         check("rand dz", 32'(adz), 32'(rd == '0));
         if (!rap && (rn[2*DW-1:DW] < rd)) begin
            check("rand true quotient", 32'(aq), 32'(rn / {8'd0, rd}));
            check("rand true remainder", 32'(ar_), 32'(rn % {8'd0, rd}));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
